// File: rtl/pkt_framer.sv
// pkt_framer: frames an AXI-Stream payload into a burst made of a generated
// header (preamble, sync, modulation field, 16-bit length, pad), the payload
// itself (zero-padded or drained on a length mismatch) and an idle gap.
// All state advances on clk_enable, the symbol-rate strobe.
//
// Ports
//   clk, rst_n       system clock, synchronous active-low reset
//   clk_enable       symbol-rate enable
//   payload_length   payload length in bits, latched at packet start
//   I_t*             AXIS payload input (I_tuser = is_bpsk for the packet)
//   O_t*             AXIS framed output (O_tuser = is_bpsk, 1 on header)
//   hdr_vld/pld_vld  output register holds a header / payload symbol
//   pkt_sent         one enabled-cycle pulse when the gap completes
//   len_err          sticky payload-length mismatch, cleared at packet start
module pkt_framer #(
    parameter int unsigned BYTES    = 1,
    parameter int unsigned PRE_LEN  = 224,
    parameter int unsigned SYNC_LEN = 32,
    parameter int unsigned MOD_LEN  = 8,
    parameter int unsigned PAD_LEN  = 40,
    parameter int unsigned GAP_LEN  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_enable,
    input  logic [15:0]        payload_length,
    input  logic [8*BYTES-1:0] I_tdata,
    input  logic               I_tvalid,
    output logic               I_tready,
    input  logic               I_tlast,
    input  logic               I_tuser,
    output logic [8*BYTES-1:0] O_tdata,
    output logic               O_tvalid,
    input  logic               O_tready,
    output logic               O_tlast,
    output logic               O_tuser,
    output logic               hdr_vld,
    output logic               pld_vld,
    output logic               pkt_sent,
    output logic               len_err
);

    localparam int unsigned BITS     = 8 * BYTES;
    localparam int unsigned SYNC_END = PRE_LEN + SYNC_LEN;
    localparam int unsigned MOD_END  = SYNC_END + MOD_LEN;
    localparam int unsigned LEN_END  = MOD_END + 16;
    localparam int unsigned HL       = LEN_END + PAD_LEN;
    localparam int unsigned HCW      = $clog2(HL + 1);
    localparam int unsigned GCW      = $clog2(GAP_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PLD,
        S_PAD,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t            r_state, w_nxt_state;
    logic [HCW-1:0]    r_hdr_cnt, w_nxt_hdr_cnt;
    logic [15:0]       r_pld_cnt, w_nxt_pld_cnt;
    logic [GCW-1:0]    r_gap_cnt, w_nxt_gap_cnt;
    logic              r_is_bpsk, w_nxt_is_bpsk;
    logic [15:0]       r_len_sym, w_nxt_len_sym;
    logic              r_len_err, w_nxt_len_err;
    logic              r_pkt_sent, w_nxt_pkt_sent;
    logic [BITS-1:0]   r_o_tdata, w_nxt_o_tdata;
    logic              r_o_tvalid, w_nxt_o_tvalid;
    logic              r_o_tlast, w_nxt_o_tlast;
    logic              r_o_tuser, w_nxt_o_tuser;
    logic              r_hdr_vld, w_nxt_hdr_vld;
    logic              r_pld_vld, w_nxt_pld_vld;

    logic              w_load;
    logic              w_hdr_last;
    logic              w_hdr_bit;
    logic [3:0]        w_len_idx;
    logic [16:0]       w_pld_inc;
    logic              w_pld_last;

    // Output register may take a new word when empty or being accepted.
    assign w_load     = clk_enable & (~r_o_tvalid | O_tready);
    assign w_hdr_last = (r_hdr_cnt == HCW'(HL - 1));
    // Length field is sent MSB first: header index MOD_END carries bit 15.
    assign w_len_idx  = 4'(HCW'(LEN_END - 1) - r_hdr_cnt);
    // 17-bit compare so LEN_SYM = 0xFFFF terminates without wrapping.
    assign w_pld_inc  = {1'b0, r_pld_cnt} + 17'd1;
    assign w_pld_last = (w_pld_inc == {1'b0, r_len_sym});

    // Ready is gated by clk_enable in DRAIN as well, so a tlast word offered
    // on a non-symbol cycle is never silently swallowed.
    assign I_tready = ((r_state == S_PLD) & w_load) | ((r_state == S_DRAIN) & clk_enable);

    assign O_tdata  = r_o_tdata;
    assign O_tvalid = r_o_tvalid;
    assign O_tlast  = r_o_tlast;
    assign O_tuser  = r_o_tuser;
    assign hdr_vld  = r_hdr_vld;
    assign pld_vld  = r_pld_vld;
    assign pkt_sent = r_pkt_sent;
    assign len_err  = r_len_err;

    // Header symbol bit for the current header index.
    always_comb begin
        w_hdr_bit = r_hdr_cnt[0];
        if (r_hdr_cnt < HCW'(PRE_LEN)) begin
            w_hdr_bit = r_hdr_cnt[0];
        end else if (r_hdr_cnt < HCW'(SYNC_END)) begin
            w_hdr_bit = ~r_hdr_cnt[0];
        end else if (r_hdr_cnt < HCW'(MOD_END)) begin
            w_hdr_bit = r_is_bpsk ^ r_hdr_cnt[0];
        end else if (r_hdr_cnt < HCW'(LEN_END)) begin
            w_hdr_bit = r_len_sym[w_len_idx];
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hdr_cnt  <= '0;
            r_pld_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_is_bpsk  <= 1'b0;
            r_len_sym  <= '0;
            r_len_err  <= 1'b0;
            r_pkt_sent <= 1'b0;
            r_o_tdata  <= '0;
            r_o_tvalid <= 1'b0;
            r_o_tlast  <= 1'b0;
            r_o_tuser  <= 1'b1;
            r_hdr_vld  <= 1'b0;
            r_pld_vld  <= 1'b0;
        end else if (clk_enable) begin
            r_state    <= w_nxt_state;
            r_hdr_cnt  <= w_nxt_hdr_cnt;
            r_pld_cnt  <= w_nxt_pld_cnt;
            r_gap_cnt  <= w_nxt_gap_cnt;
            r_is_bpsk  <= w_nxt_is_bpsk;
            r_len_sym  <= w_nxt_len_sym;
            r_len_err  <= w_nxt_len_err;
            r_pkt_sent <= w_nxt_pkt_sent;
            r_o_tdata  <= w_nxt_o_tdata;
            r_o_tvalid <= w_nxt_o_tvalid;
            r_o_tlast  <= w_nxt_o_tlast;
            r_o_tuser  <= w_nxt_o_tuser;
            r_hdr_vld  <= w_nxt_hdr_vld;
            r_pld_vld  <= w_nxt_pld_vld;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_hdr_cnt  = r_hdr_cnt;
        w_nxt_pld_cnt  = r_pld_cnt;
        w_nxt_gap_cnt  = '0;
        w_nxt_is_bpsk  = r_is_bpsk;
        w_nxt_len_sym  = r_len_sym;
        w_nxt_len_err  = r_len_err;
        w_nxt_pkt_sent = 1'b0;
        w_nxt_o_tdata  = r_o_tdata;
        w_nxt_o_tvalid = r_o_tvalid;
        w_nxt_o_tlast  = r_o_tlast;
        w_nxt_o_tuser  = r_o_tuser;
        w_nxt_hdr_vld  = r_hdr_vld;
        w_nxt_pld_vld  = r_pld_vld;

        // A load with nothing new to present empties the output register.
        if (w_load) begin
            w_nxt_o_tvalid = 1'b0;
            w_nxt_o_tlast  = 1'b0;
            w_nxt_hdr_vld  = 1'b0;
            w_nxt_pld_vld  = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (I_tvalid) begin
                    w_nxt_state   = S_HDR;
                    w_nxt_is_bpsk = I_tuser;
                    w_nxt_len_sym = I_tuser ? payload_length : (payload_length >> 1);
                    w_nxt_len_err = 1'b0;
                    w_nxt_hdr_cnt = '0;
                    w_nxt_pld_cnt = '0;
                end
            end

            S_HDR: begin
                if (w_load) begin
                    w_nxt_o_tvalid = 1'b1;
                    w_nxt_o_tdata  = {BITS{w_hdr_bit}};
                    w_nxt_o_tuser  = 1'b1;
                    w_nxt_hdr_vld  = 1'b1;
                    w_nxt_o_tlast  = w_hdr_last & (r_len_sym == 16'd0);
                    w_nxt_hdr_cnt  = r_hdr_cnt + HCW'(1);
                    if (w_hdr_last) begin
                        w_nxt_hdr_cnt = '0;
                        w_nxt_pld_cnt = '0;
                        w_nxt_state   = (r_len_sym != 16'd0) ? S_PLD : S_GAP;
                    end
                end
            end

            S_PLD: begin
                if (w_load && I_tvalid) begin
                    w_nxt_o_tvalid = 1'b1;
                    w_nxt_o_tdata  = I_tdata;
                    w_nxt_o_tuser  = r_is_bpsk;
                    w_nxt_pld_vld  = 1'b1;
                    w_nxt_o_tlast  = w_pld_last;
                    w_nxt_pld_cnt  = w_pld_inc[15:0];
                    if (w_pld_last) begin
                        if (I_tlast) begin
                            w_nxt_state = S_GAP;
                        end else begin
                            w_nxt_len_err = 1'b1;
                            w_nxt_state   = S_DRAIN;
                        end
                    end else if (I_tlast) begin
                        w_nxt_len_err = 1'b1;
                        w_nxt_state   = S_PAD;
                    end
                end
            end

            S_PAD: begin
                if (w_load) begin
                    w_nxt_o_tvalid = 1'b1;
                    w_nxt_o_tdata  = '0;
                    w_nxt_o_tuser  = r_is_bpsk;
                    w_nxt_pld_vld  = 1'b1;
                    w_nxt_o_tlast  = w_pld_last;
                    w_nxt_pld_cnt  = w_pld_inc[15:0];
                    if (w_pld_last) begin
                        w_nxt_state = S_GAP;
                    end
                end
            end

            S_DRAIN: begin
                // Over-length source: swallow words until its tlast or a bubble.
                if (!I_tvalid || I_tlast) begin
                    w_nxt_state = S_GAP;
                end
            end

            S_GAP: begin
                // The first load here is the acceptance of the final word;
                // every load after that is one idle symbol.
                w_nxt_gap_cnt = r_gap_cnt;
                if (w_load) begin
                    if (r_gap_cnt == GCW'(GAP_LEN - 1)) begin
                        w_nxt_gap_cnt  = '0;
                        w_nxt_pkt_sent = 1'b1;
                        w_nxt_state    = S_IDLE;
                    end else begin
                        w_nxt_gap_cnt = r_gap_cnt + GCW'(1);
                    end
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pkt_framer.sv
// Scoreboard bench for pkt_framer (default parameters, BYTES=1).
module tb_pkt_framer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       hdr;
        logic       pld;
    } word_t;

    logic        clk;
    logic        rst_n;
    logic        clk_enable;
    logic [15:0] payload_length;
    logic [7:0]  I_tdata;
    logic        I_tvalid;
    logic        I_tready;
    logic        I_tlast;
    logic        I_tuser;
    logic [7:0]  O_tdata;
    logic        O_tvalid;
    logic        O_tready;
    logic        O_tlast;
    logic        O_tuser;
    logic        hdr_vld;
    logic        pld_vld;
    logic        pkt_sent;
    logic        len_err;

    pkt_framer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_enable     (clk_enable),
        .payload_length (payload_length),
        .I_tdata        (I_tdata),
        .I_tvalid       (I_tvalid),
        .I_tready       (I_tready),
        .I_tlast        (I_tlast),
        .I_tuser        (I_tuser),
        .O_tdata        (O_tdata),
        .O_tvalid       (O_tvalid),
        .O_tready       (O_tready),
        .O_tlast        (O_tlast),
        .O_tuser        (O_tuser),
        .hdr_vld        (hdr_vld),
        .pld_vld        (pld_vld),
        .pkt_sent       (pkt_sent),
        .len_err        (len_err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_xfer   = 0;
    int          pkt_seen = 0;
    int          idle_cnt = 0;
    int          exp_gap  = 0;
    bit          in_gap   = 0;
    bit          ce_off   = 0;
    bit          rnd_rdy  = 0;
    word_t       sb[$];
    logic [7:0]  src_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Symbol enable: one clock in four.
    initial begin
        int div;
        div = 0;
        clk_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            clk_enable = !ce_off && (div == 0);
        end
    end

    // Downstream ready: constant 1 or 50% random.
    initial begin
        O_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            O_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (n_xfer=%0d)", n_xfer);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: each accepted output word is popped and compared.
    initial begin
        word_t e;
        word_t a;
        forever begin
            @(negedge clk);
            if (rst_n && clk_enable) begin
                if (O_tvalid && O_tready) begin
                    n_xfer++;
                    a = {O_tdata, O_tlast, O_tuser, hdr_vld, pld_vld};
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_word: got 0x%0h expected no word at %0t", a, $time);
                    end else begin
                        e = sb.pop_front();
                        check("out_word", 32'(a), 32'(e));
                    end
                    if (O_tlast) begin
                        idle_cnt = 0;
                        in_gap   = 1;
                    end
                end else if (!O_tvalid && in_gap) begin
                    idle_cnt++;
                end
                if (pkt_sent) begin
                    if (exp_gap != 0) check("gap_len", 32'(idle_cnt), 32'(exp_gap));
                    in_gap = 0;
                    pkt_seen++;
                end
            end
        end
    end

    task automatic push_w(input logic [7:0] d, input logic l, input logic u, input logic h, input logic p);
        word_t w;
        w = {d, l, u, h, p};
        sb.push_back(w);
    endtask

    // Default layout: 224 preamble, 32 sync, 8 mod, 16 length, 40 pad = 320.
    task automatic push_header(input logic bpsk, input logic [15:0] len);
        logic b;
        for (int i = 0; i < 320; i++) begin
            if (i < 224)      b = 1'(i % 2);
            else if (i < 256) b = !(i % 2);
            else if (i < 264) b = bpsk ^ 1'(i % 2);
            else if (i < 280) b = len[15 - (i - 264)];
            else              b = 1'(i % 2);
            push_w({8{b}}, (len == 16'd0) && (i == 319), 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic send(input int tlast_at, input bit gaps);
        int k;
        int base;
        if (src_q.size() == 0) begin
            base = n_xfer;
            I_tvalid = 1'b1;
            I_tdata  = 8'hEE;
            I_tlast  = 1'b1;
            for (k = 0; k < 20000; k++) begin
                @(negedge clk);
                if (n_xfer > base) break;
            end
            check("hdr_start", 32'(k < 20000), 32'd1);
            @(posedge clk);
            #1;
            I_tvalid = 1'b0;
            I_tlast  = 1'b0;
            return;
        end
        for (int i = 0; i < src_q.size(); i++) begin
            if (gaps && (i % 2 == 1)) begin
                I_tvalid = 1'b0;
                repeat (9) @(posedge clk);
                #1;
            end
            I_tvalid = 1'b1;
            I_tdata  = src_q[i];
            I_tlast  = (i == tlast_at);
            for (k = 0; k < 20000; k++) begin
                @(negedge clk);
                if (I_tready) break;
            end
            check("src_accept", 32'(k < 20000), 32'd1);
            @(posedge clk);
            #1;
        end
        I_tvalid = 1'b0;
        I_tlast  = 1'b0;
    endtask

    task automatic run_pkt(input logic bpsk, input logic [15:0] plen, input int tlast_at,
                           input bit gaps, input logic exp_err, input int gap_v);
        int start;
        int k;
        exp_gap        = gap_v;
        I_tuser        = bpsk;
        payload_length = plen;
        start          = pkt_seen;
        send(tlast_at, gaps);
        for (k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (pkt_seen > start) break;
        end
        check("pkt_sent", 32'(pkt_seen > start), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("len_err", 32'(len_err), 32'(exp_err));
    endtask

    function automatic logic [15:0] outs();
        return {O_tvalid, O_tdata, O_tlast, O_tuser, I_tready, hdr_vld, pld_vld, pkt_sent, len_err};
    endfunction

    initial begin
        int k;
        int base;
        rst_n = 1'b0;
        I_tvalid = 1'b0;
        I_tdata = 8'h00;
        I_tlast = 1'b0;
        I_tuser = 1'b0;
        payload_length = 16'd0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(outs()), 32'h0020);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // BPSK, 4 words, nominal.
        push_header(1'b1, 16'h0004);
        push_w(8'hA1, 0, 1, 0, 1); push_w(8'hB2, 0, 1, 0, 1);
        push_w(8'hC3, 0, 1, 0, 1); push_w(8'hD4, 1, 1, 0, 1);
        src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_pkt(1'b1, 16'd4, 3, 0, 1'b0, 4);

        // QPSK, 8 bits -> 4 symbols, mod field 0101...
        push_header(1'b0, 16'h0004);
        push_w(8'h11, 0, 0, 0, 1); push_w(8'h22, 0, 0, 0, 1);
        push_w(8'h33, 0, 0, 0, 1); push_w(8'h44, 1, 0, 0, 1);
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(1'b0, 16'd8, 3, 0, 1'b0, 4);

        // Nominal packet again with random backpressure and source bubbles.
        rnd_rdy = 1;
        push_header(1'b1, 16'h0004);
        push_w(8'hA1, 0, 1, 0, 1); push_w(8'hB2, 0, 1, 0, 1);
        push_w(8'hC3, 0, 1, 0, 1); push_w(8'hD4, 1, 1, 0, 1);
        src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_pkt(1'b1, 16'd4, 3, 1, 1'b0, 4);
        rnd_rdy = 0;

        // Short source: 3 words of 6, zero-padded.
        push_header(1'b1, 16'h0006);
        push_w(8'h5A, 0, 1, 0, 1); push_w(8'hA5, 0, 1, 0, 1); push_w(8'h3C, 0, 1, 0, 1);
        push_w(8'h00, 0, 1, 0, 1); push_w(8'h00, 0, 1, 0, 1); push_w(8'h00, 1, 1, 0, 1);
        src_q = '{8'h5A, 8'hA5, 8'h3C};
        run_pkt(1'b1, 16'd6, 2, 0, 1'b1, 4);

        // Long source: 5 words for a 2-symbol payload, 3 drained.
        push_header(1'b1, 16'h0002);
        push_w(8'h01, 0, 1, 0, 1); push_w(8'h02, 1, 1, 0, 1);
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_pkt(1'b1, 16'd2, 4, 0, 1'b1, 0);

        // Zero length: header only, tlast on symbol 320.
        push_header(1'b1, 16'h0000);
        src_q = {};
        run_pkt(1'b1, 16'd0, 0, 0, 1'b0, 4);

        // Reset around header symbol 100 with clk_enable low.
        push_header(1'b1, 16'h0004);
        I_tuser = 1'b1;
        payload_length = 16'd4;
        base = n_xfer;
        I_tvalid = 1'b1;
        I_tdata = 8'hA1;
        I_tlast = 1'b0;
        for (k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (n_xfer - base >= 100) break;
        end
        check("hdr_100", 32'(k < 20000), 32'd1);
        ce_off = 1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        I_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_ce0", 32'(outs()), 32'h0020);
        check("mid_reset_ce", 32'(clk_enable), 32'd0);
        sb.delete();
        in_gap = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ce_off = 0;
        repeat (8) @(posedge clk);
        #1;

        // Clean packet after the abandoned frame.
        push_header(1'b1, 16'h0004);
        push_w(8'hA1, 0, 1, 0, 1); push_w(8'hB2, 0, 1, 0, 1);
        push_w(8'hC3, 0, 1, 0, 1); push_w(8'hD4, 1, 1, 0, 1);
        src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_pkt(1'b1, 16'd4, 3, 0, 1'b0, 4);

        repeat (8) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
